// File: rtl/dnn_pkg.sv
//------------------------------------------------------------------------------
// Module : dnn_pkg
// Brief  : Shared widths and sequencer state encoding for the DNN output path.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dnn_pkg;

    localparam int DNN_DATA_W = 16;
    localparam int DNN_ADDR_W = 2;
    localparam int DNN_N_OUT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/output_seq_ctrl_argmax_tracker.sv
//------------------------------------------------------------------------------
// Module : argmax_tracker
// Brief  : Running signed maximum and its index; ties keep the earliest index.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module argmax_tracker
    import dnn_pkg::*;
#(
    parameter int DATA_W = DNN_DATA_W,
    parameter int ADDR_W = DNN_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] index,
    output logic [DATA_W-1:0] best_val,
    output logic [ADDR_W-1:0] best_idx
);

    logic              r_has_best;
    logic [DATA_W-1:0] r_best_val;
    logic [ADDR_W-1:0] r_best_idx;
    logic              w_take;

    // Strictly-greater replacement keeps the lowest index on ties.
    assign w_take = valid && (!r_has_best || ($signed(data) > $signed(r_best_val)));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_has_best <= 1'b0;
            r_best_val <= '0;
            r_best_idx <= '0;
        end else if (w_take) begin
            r_has_best <= 1'b1;
            r_best_val <= data;
            r_best_idx <= index;
        end
    end

    assign best_val = r_best_val;
    assign best_idx = r_best_idx;

endmodule

`default_nettype wire

// File: rtl/output_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : output_seq_ctrl
// Brief  : Writes one frame of neuron results into the output bank and
//          publishes the argmax class on a one-cycle done pulse.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module output_seq_ctrl
    import dnn_pkg::*;
#(
    parameter int DATA_W = DNN_DATA_W,
    parameter int N_OUT  = DNN_N_OUT,
    parameter int ADDR_W = DNN_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] class_idx,
    output logic [DATA_W-1:0] class_val
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(N_OUT - 1);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_en;
    logic              r_done;
    logic [ADDR_W-1:0] r_class_idx;
    logic [DATA_W-1:0] r_class_val;
    logic              w_in_ready;
    logic              w_busy;
    logic              w_start_frame;
    logic              w_hs;
    logic [DATA_W-1:0] w_best_val;
    logic [ADDR_W-1:0] w_best_idx;

    always_comb begin
        w_next_state  = r_state;
        w_in_ready    = 1'b0;
        w_busy        = 1'b0;
        w_start_frame = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A start coinciding with the done pulse belongs to the old frame.
                if (start && !r_done) begin
                    w_next_state  = ST_COLLECT;
                    w_start_frame = 1'b1;
                end
            end
            ST_COLLECT: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (in_valid && (r_count == c_LAST_IDX)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_hs = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_wr_data   <= '0;
            r_wr_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_done      <= 1'b0;
            r_class_idx <= '0;
            r_class_val <= '0;
        end else begin
            r_state <= w_next_state;
            r_wr_en <= w_hs;
            r_done  <= (r_state == ST_DONE);
            if (w_start_frame) begin
                r_count <= '0;
            end else if (w_hs) begin
                r_wr_data <= in_data;
                r_wr_addr <= r_count;
                // Saturate so the address can never step past the last slot.
                if (r_count != c_LAST_IDX) begin
                    r_count <= r_count + ADDR_W'(1);
                end
            end
            if (r_state == ST_DONE) begin
                r_class_idx <= w_best_idx;
                r_class_val <= w_best_val;
            end
        end
    end

    argmax_tracker #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_start_frame),
        .valid    (w_hs),
        .data     (in_data),
        .index    (r_count),
        .best_val (w_best_val),
        .best_idx (w_best_idx)
    );

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign wr_data   = r_wr_data;
    assign wr_addr   = r_wr_addr;
    assign wr_en     = r_wr_en;
    assign done      = r_done;
    assign class_idx = r_class_idx;
    assign class_val = r_class_val;

endmodule

`default_nettype wire

// File: tb/tb_output_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_output_seq_ctrl
// Brief  : Scoreboard bench for output_seq_ctrl with a frame-level argmax model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_output_seq_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 2;
    localparam int N_OUT  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] class_idx;
    logic [DATA_W-1:0] class_val;

    output_seq_ctrl #(
        .DATA_W (DATA_W),
        .N_OUT  (N_OUT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx),
        .class_val (class_val)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t wr_q[$];
    exp_t dn_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] fv [N_OUT];
    int                fg [N_OUT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write and every done pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_wr_en", 32'd1, 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
            if (done) begin
                if (dn_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = dn_q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("class_idx", 32'(class_idx), 32'(e.addr));
                    check("class_val", 32'(class_val), 32'(e.data));
                end
            end
        end
    end

    // Reference: first maximum in signed order over the frame.
    task automatic ref_argmax(output logic [ADDR_W-1:0] idx, output logic [DATA_W-1:0] val);
        int bi = 0;
        for (int i = 1; i < N_OUT; i++) begin
            if ($signed(fv[i]) > $signed(fv[bi])) bi = i;
        end
        idx = ADDR_W'(bi);
        val = fv[bi];
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && (wr_q.size() != 0 || dn_q.size() != 0); k++) begin
            @(posedge clk); #1;
        end
        if (wr_q.size() != 0 || dn_q.size() != 0) begin
            check("scoreboard_drain_timeout", 32'(wr_q.size() + dn_q.size()), 32'd0);
            wr_q.delete();
            dn_q.delete();
        end
    endtask

    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic run_frame(input bit mid_start, input bit start_on_done);
        exp_t e;
        logic [ADDR_W-1:0] ri;
        logic [DATA_W-1:0] rv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < N_OUT; i++) begin
            for (int g = 0; g < fg[i]; g++) begin
                in_valid = 1'b0;
                if (mid_start && g == 0) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = fv[i];
            check("in_ready_collect", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            e.cyc = cyc; e.addr = ADDR_W'(i); e.data = fv[i];
            wr_q.push_back(e);
            in_valid = 1'b0;
            in_data  = DATA_W'($urandom);
        end
        ref_argmax(ri, rv);
        e.cyc = cyc + 1; e.addr = ri; e.data = rv;
        dn_q.push_back(e);
        check("in_ready_done_state", 32'(in_ready), 32'd0);
        check("busy_done_state", 32'(busy), 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_on_done_cycle", 32'(busy), 32'd0);
        start = start_on_done;
        @(posedge clk); #1;
        start = 1'b0;
        if (start_on_done) check("start_with_done_ignored", 32'(in_ready), 32'd0);
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_class", 32'({class_idx, class_val}), 32'd0);
        check("rst_wr", 32'({wr_addr, wr_data}), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            @(posedge clk); #1;
            check("idle_wr_en", 32'(wr_en), 32'd0);
            check("idle_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        fv[0] = 16'd5; fv[1] = 16'd9; fv[2] = 16'd2;
        fg[0] = 0; fg[1] = 0; fg[2] = 0;
        run_frame(1'b0, 1'b1);

        fv[0] = 16'hFFF0; fv[1] = 16'hFFFF; fv[2] = 16'h8000;
        run_frame(1'b0, 1'b0);

        fv[0] = 16'd7; fv[1] = 16'd7; fv[2] = 16'd3;
        run_frame(1'b0, 1'b0);

        fv[0] = 16'd100; fv[1] = 16'h8001; fv[2] = 16'd101;
        fg[0] = 0; fg[1] = 2; fg[2] = 1;
        run_frame(1'b1, 1'b0);

        // Abort a frame after its second accepted result.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            in_valid = 1'b1;
            in_data  = 16'(i + 40);
            @(posedge clk); #1;
            e.cyc = cyc; e.addr = ADDR_W'(i); e.data = 16'(i + 40);
            wr_q.push_back(e);
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_class_idx", 32'(class_idx), 32'd0);
        check("abort_class_val", 32'(class_val), 32'd0);
        check("abort_wr_en", 32'(wr_en), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 32'd0);

        fv[0] = 16'd1; fv[1] = 16'd3; fv[2] = 16'd2;
        fg[0] = 0; fg[1] = 0; fg[2] = 0;
        run_frame(1'b0, 1'b0);

        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < N_OUT; i++) begin
                fv[i] = ($urandom_range(0, 1) == 1) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 3));
                fg[i] = $urandom_range(0, 2);
            end
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
